controller_sequencer: RTL and testbench

//  Control-word generator and sequencer for the 8-bit W-bus microprocessor.
//  A 6-state one-hot ring counter (T1..T6) drives fetch (T1-T3) and execute (T4-T6).

---
 rtl/controller_sequencer_pkg.sv | 44 ++++
 rtl/controller_sequencer_ring_counter.sv | 28 ++
 rtl/controller_sequencer.sv | 131 +++++++++++++
 tb/tb_controller_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the W-bus controller/sequencer: opcodes, one-hot
// T-state encodings, control-word bit positions and the idle control word.
package controller_sequencer_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned T_W  = 6;
  localparam int unsigned CW_W = 12;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  localparam int unsigned CW_CP   = 0;
  localparam int unsigned CW_EP   = 1;
  localparam int unsigned CW_LM_N = 2;
  localparam int unsigned CW_CE_N = 3;
  localparam int unsigned CW_LI_N = 4;
  localparam int unsigned CW_EI_N = 5;
  localparam int unsigned CW_LA_N = 6;
  localparam int unsigned CW_EA   = 7;
  localparam int unsigned CW_SU   = 8;
  localparam int unsigned CW_EU   = 9;
  localparam int unsigned CW_LB_N = 10;
  localparam int unsigned CW_LO_N = 11;

  // All active-low strobes high, all active-high strobes low.
  localparam logic [CW_W-1:0] CW_INACTIVE = 12'hC7C;

  // True for opcodes that do real work; everything else executes as NOP.
  function automatic logic is_defined_op(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring counter.
// Ports: clk, clr (sync clear to T1), hold (freeze), wrap (return to T1
// early), state (one-hot, bit0 = T1). A non-one-hot state recovers to T1.
module controller_sequencer_ring_counter
  import controller_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           hold,
  input  logic           wrap,
  output logic [T_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= T1;
    end else if (!$onehot(state)) begin
      state <= T1;
    end else if (hold) begin
      state <= state;
    end else if (wrap) begin
      state <= T1;
    end else begin
      state <= {state[T_W-2:0], state[T_W-1]};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// Controller/sequencer for the 8-bit W-bus processor. A one-hot ring
// T1..T6 sequences fetch (T1-T3) and execute (T4-T6); the control word is
// decoded combinationally from {t_state, op_code}.
// Ports: clk, clr (sync active-high clear), op_code (from IR);
//   strobes cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
//   hlt (registered halt flag); t_state (one-hot, bit0 = T1).
// Build option: define SKIP_NOP_EN to wrap the ring to T1 right after the
// last useful T-state of LDA, OUT and NOP instead of always using six states.
module controller_sequencer
  import controller_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] op_code,
  output logic            cp,
  output logic            ep,
  output logic            lm_n,
  output logic            ce_n,
  output logic            li_n,
  output logic            ei_n,
  output logic            la_n,
  output logic            ea,
  output logic            su,
  output logic            eu,
  output logic            lb_n,
  output logic            lo_n,
  output logic            hlt,
  output logic [T_W-1:0]  t_state
);

  logic [CW_W-1:0] cw;
  logic            hlt_entry_c;
  logic            hold_c;
  logic            wrap_c;

  // HLT is recognised in T4; the ring must not leave T4 on that same edge.
  assign hlt_entry_c = (t_state == T4) && (op_code == OP_HLT);
  assign hold_c      = hlt || hlt_entry_c;

`ifdef SKIP_NOP_EN
  // Early return to T1 once the instruction has no further strobes.
  assign wrap_c = ((t_state == T3) && !is_defined_op(op_code)) ||
                  ((t_state == T4) && (op_code == OP_OUT)) ||
                  ((t_state == T5) && (op_code == OP_LDA));
`else
  assign wrap_c = 1'b0;
`endif

  controller_sequencer_ring_counter u_ring (
    .clk   (clk),
    .clr   (clr),
    .hold  (hold_c),
    .wrap  (wrap_c),
    .state (t_state)
  );

  // Halt flag: set on the T4 edge of HLT, cleared only by clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      hlt <= 1'b0;
    end else if (hlt_entry_c) begin
      hlt <= 1'b1;
    end
  end

  // Control-word decode; idle while clearing or halted.
  always_comb begin
    cw = CW_INACTIVE;
    if (!clr && !hlt) begin
      case (t_state)
        T1: begin
          cw[CW_EP]   = 1'b1;
          cw[CW_LM_N] = 1'b0;
        end
        T2: cw[CW_CP] = 1'b1;
        T3: begin
          cw[CW_CE_N] = 1'b0;
          cw[CW_LI_N] = 1'b0;
        end
        T4: begin
          case (op_code)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw[CW_EI_N] = 1'b0;
              cw[CW_LM_N] = 1'b0;
            end
            OP_OUT: begin
              cw[CW_EA]   = 1'b1;
              cw[CW_LO_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (op_code)
            OP_LDA: begin
              cw[CW_CE_N] = 1'b0;
              cw[CW_LA_N] = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_CE_N] = 1'b0;
              cw[CW_LB_N] = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          if ((op_code == OP_ADD) || (op_code == OP_SUB)) begin
            cw[CW_EU]   = 1'b1;
            cw[CW_LA_N] = 1'b0;
            cw[CW_SU]   = (op_code == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: directed scenarios followed
// by random opcodes/clears, compared against a step-number reference model
// through an expectation queue drained by an independent monitor.
module tb_controller_sequencer;

  logic       clk;
  logic       clr;
  logic [3:0] op_code;
  logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;
  logic [5:0] t_state;

  typedef struct packed {
    logic [11:0] strobes;
    logic        halt;
    logic [5:0]  tst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: step 1..6 and halted flag, plus inputs in force.
  int         m_t;
  bit         m_h;
  bit         cur_clr;
  logic [3:0] cur_op;

  controller_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .op_code (op_code),
    .cp      (cp),
    .ep      (ep),
    .lm_n    (lm_n),
    .ce_n    (ce_n),
    .li_n    (li_n),
    .ei_n    (ei_n),
    .la_n    (la_n),
    .ea      (ea),
    .su      (su),
    .eu      (eu),
    .lb_n    (lb_n),
    .lo_n    (lo_n),
    .hlt     (hlt),
    .t_state (t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_nop(input logic [3:0] op);
    return !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hE || op == 4'hF);
  endfunction

  // Strobes in order {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n}.
  function automatic logic [11:0] exp_strobes(input bit c, input bit h,
                                              input int t, input logic [3:0] op);
    logic s_cp = 0, s_ep = 0, s_ea = 0, s_su = 0, s_eu = 0;
    logic s_lm = 1, s_ce = 1, s_li = 1, s_ei = 1, s_la = 1, s_lb = 1, s_lo = 1;
    if (!c && !h) begin
      case (t)
        1: begin s_ep = 1; s_lm = 0; end
        2: s_cp = 1;
        3: begin s_ce = 0; s_li = 0; end
        4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin s_ei = 0; s_lm = 0; end
           else if (op == 4'hE) begin s_ea = 1; s_lo = 0; end
        5: if (op == 4'h0) begin s_ce = 0; s_la = 0; end
           else if (op == 4'h1 || op == 4'h2) begin s_ce = 0; s_lb = 0; end
        6: if (op == 4'h1 || op == 4'h2) begin s_eu = 1; s_la = 0; s_su = (op == 4'h2); end
        default: ;
      endcase
    end
    return {s_cp, s_ep, s_lm, s_ce, s_li, s_ei, s_la, s_ea, s_su, s_eu, s_lb, s_lo};
  endfunction

  // Advance the model across one clock edge using the inputs that were applied.
  task automatic model_step();
    if (cur_clr) begin
      m_t = 1; m_h = 0;
    end else if (m_h) begin
      m_t = m_t;
    end else if (m_t == 4 && cur_op == 4'hF) begin
      m_h = 1;
`ifdef SKIP_NOP_EN
    end else if ((m_t == 3 && is_nop(cur_op)) || (m_t == 4 && cur_op == 4'hE) ||
                 (m_t == 5 && cur_op == 4'h0)) begin
      m_t = 1;
`endif
    end else begin
      m_t = (m_t == 6) ? 1 : m_t + 1;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.strobes = exp_strobes(cur_clr, m_h, m_t, cur_op);
    e.halt    = m_h;
    e.tst     = 6'(1) << (m_t - 1);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit c, input logic [3:0] o);
    @(posedge clk);
    #2;
    model_step();
    cur_clr = c; cur_op = o;
    clr = c; op_code = o;
    push_expect();
  endtask

  task automatic run(input bit c, input logic [3:0] o, input int n);
    for (int i = 0; i < n; i++) cycle(c, o);
  endtask

  // Monitor: every cycle the DUT presents a control word; compare mid-cycle.
  initial begin
    exp_t e;
    logic [11:0] got;
    int drivers;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};
        checks++;
        if (got !== e.strobes) begin
          errors++;
          $display("FAIL strobes t=%0t: got %b required %b (t_state=%b op=%h)",
                   $time, got, e.strobes, t_state, op_code);
        end
        checks++;
        if (hlt !== e.halt) begin
          errors++;
          $display("FAIL hlt t=%0t: got %b required %b", $time, hlt, e.halt);
        end
        checks++;
        if (t_state !== e.tst) begin
          errors++;
          $display("FAIL t_state t=%0t: got %b required %b", $time, t_state, e.tst);
        end
        checks++;
        if (!$onehot(t_state)) begin
          errors++;
          $display("FAIL onehot t=%0t: got %b required one-hot", $time, t_state);
        end
        drivers = int'(ep) + int'(!ce_n) + int'(!ei_n) + int'(ea) + int'(eu);
        checks++;
        if (drivers > 1) begin
          errors++;
          $display("FAIL bus_drivers t=%0t: got %0d required <=1", $time, drivers);
        end
      end
    end
  end

  initial begin
    logic [3:0] ops [8];
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE;
    ops[4] = 4'h3; ops[5] = 4'h7; ops[6] = 4'h9; ops[7] = 4'hF;

    clr = 1'b1; op_code = 4'h3;
    cur_clr = 1'b1; cur_op = 4'h3;
    @(posedge clk);
    #2;
    m_t = 1; m_h = 0;
    push_expect();
    cycle(1'b1, 4'h3);              // clear held two cycles

    run(1'b0, 4'h0, 8);             // LDA through T6 and back into T1
    cycle(1'b1, 4'h3);
    run(1'b0, 4'h2, 6);             // SUB
    run(1'b0, 4'h1, 6);             // ADD
    run(1'b0, 4'hF, 25);            // HLT, then hold
    cycle(1'b1, 4'hF);              // clear out of halt
    run(1'b0, 4'h0, 6);
    run(1'b0, 4'h1, 4);             // ADD up to T5
    cycle(1'b1, 4'h1);              // clear during T5
    run(1'b0, 4'h1, 3);
    cycle(1'b1, 4'h0);
    run(1'b0, 4'hE, 7);             // OUT
    cycle(1'b1, 4'h0);
    run(1'b0, 4'h7, 7);             // undefined opcode
    cycle(1'b1, 4'h0);
    run(1'b0, 4'h0, 7);             // LDA again for early wrap case

    for (int i = 0; i < 500; i++) begin
      logic [3:0] o;
      int r;
      r = $urandom_range(0, 15);
      o = (r < 7) ? ops[r] : ((r == 15) ? 4'hF : ops[r % 7]);
      cycle($urandom_range(0, 24) == 0, o);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
